// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU: state, ALU, opcode
// and PC-source encodings, plus the opcode classifier.
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [2:0] {
        K_ALU,
        K_LS,
        K_BR,
        K_JMP,
        K_HALT,
        K_NOP
    } op_kind_e;

    function automatic op_kind_e op_kind(input logic [5:0] op);
        op_kind_e k;
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU,
            OP_AND, OP_ANDI, OP_OR, OP_ORI,
            OP_SLL, OP_SLT, OP_SLTI: k = K_ALU;
            OP_SW, OP_LW:            k = K_LS;
            OP_BEQ, OP_BNE:          k = K_BR;
            OP_J:                    k = K_JMP;
            OP_HALT:                 k = K_HALT;
            default:                 k = K_NOP;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_op_decode.sv
// Opcode to ALU function and operand-select map for the
// arithmetic/logic instruction group.
module alu_op_decode
    import cpu_defs_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic       r_type
);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        r_type    = 1'b0;
        case (opcode)
            OP_ADD:   r_type = 1'b1;
            OP_SUB: begin
                alu_op = ALU_SUB;
                r_type = 1'b1;
            end
            OP_ADDIU: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
            end
            OP_AND: begin
                alu_op = ALU_AND;
                r_type = 1'b1;
            end
            OP_ANDI: begin
                alu_op    = ALU_AND;
                alu_src_b = 1'b1;
            end
            OP_OR: begin
                alu_op = ALU_OR;
                r_type = 1'b1;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            OP_SLL: begin
                alu_op    = ALU_SLL;
                alu_src_a = 1'b1;
                r_type    = 1'b1;
            end
            OP_SLT: begin
                alu_op = ALU_SLT;
                r_type = 1'b1;
            end
            OP_SLTI: begin
                alu_op    = ALU_SLT;
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: drives datapath enables and the ALU
// opcode from (state, opcode, zero).
module mc_control_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned PC_INC      = 4,
    parameter bit          HALT_STICKY = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       mRD,
    output logic       mWR
);

    // The datapath adder steps the PC by whole instruction words.
    if (PC_INC % 4 != 0) begin : g_pc_inc_unaligned
    end

    state_e state_q, state_d;
    logic   halt_q, halt_d;

    logic [2:0] dec_alu_op;
    logic       dec_src_a;
    logic       dec_src_b;
    logic       dec_ext;
    logic       dec_r_type;
    logic       taken;

    alu_op_decode u_alu_op_decode (
        .opcode    (opcode),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext),
        .r_type    (dec_r_type)
    );

    assign taken = (opcode == OP_BEQ) ? zero : !zero;

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        state     = state_q;
        PCWre     = 1'b0;
        PCSrc     = PCSRC_SEQ;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (Reset) begin
            state = ST_IF;
        end else begin
            case (state_q)
                ST_IF: begin
                    IRWre   = 1'b1;
                    state_d = ST_ID;
                end
                ST_ID: begin
                    // ID doubles as HALT when the halt flag is set
                    if (halt_q) begin
                        if (!HALT_STICKY) begin
                            state_d = ST_IF;
                            halt_d  = 1'b0;
                        end
                    end else begin
                        case (op_kind(opcode))
                            K_ALU:  state_d = ST_EXE_AL;
                            K_LS:   state_d = ST_EXE_LS;
                            K_BR:   state_d = ST_EXE_BR;
                            K_HALT: halt_d  = 1'b1;
                            K_JMP: begin
                                PCWre   = 1'b1;
                                PCSrc   = PCSRC_JMP;
                                state_d = ST_IF;
                            end
                            default: begin
                                PCWre   = 1'b1;
                                state_d = ST_IF;
                            end
                        endcase
                    end
                end
                ST_EXE_AL: begin
                    ALUOp   = dec_alu_op;
                    ALUSrcA = dec_src_a;
                    ALUSrcB = dec_src_b;
                    ExtSel  = dec_ext;
                    state_d = ST_WB_AL;
                end
                ST_WB_AL: begin
                    ALUOp     = dec_alu_op;
                    RegDst    = dec_r_type;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    state_d   = ST_IF;
                end
                ST_EXE_LS: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    state_d = ST_MEM;
                end
                ST_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    if (opcode == OP_SW) begin
                        mWR     = 1'b1;
                        PCWre   = 1'b1;
                        state_d = ST_IF;
                    end else begin
                        mRD     = 1'b1;
                        state_d = ST_WB_LD;
                    end
                end
                ST_WB_LD: begin
                    RegWre  = 1'b1;
                    PCWre   = 1'b1;
                    state_d = ST_IF;
                end
                ST_EXE_BR: begin
                    ALUOp   = ALU_SUB;
                    ExtSel  = 1'b1;
                    PCWre   = 1'b1;
                    PCSrc   = taken ? PCSRC_BR : PCSRC_SEQ;
                    state_d = ST_IF;
                end
                default: state_d = ST_IF;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IF;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed vector table, hand-written
// reset/halt sequences and randomized programs against a trace model.
module tb_mc_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB;
    logic       RegDst, RegWre, WrRegDSrc, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;

    mc_control_unit #(.PC_INC(4), .HALT_STICKY(1'b1)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre),
        .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcwre;
        logic [1:0] pcsrc;
        logic       irwre;
        logic       ext;
        logic       srca;
        logic       srcb;
        logic [2:0] aluop;
        logic       regdst;
        logic       regwre;
        logic       wrsrc;
        logic       mrd;
        logic       mwr;
    } ctl_t;

    typedef struct packed {
        logic [2:0] st;
        ctl_t       c;
    } step_t;

    typedef struct {
        logic [5:0]      op;
        logic            z;
        int              n;
        logic [4:0][2:0] st;
        int              key;
        ctl_t            kc;
    } vec_t;

    ctl_t  ctl;
    ctl_t  ir_only;
    int    checks = 0;
    int    errors = 0;
    step_t exp_q[$];
    vec_t  vt[$];

    assign ctl = {PCWre, PCSrc, IRWre, ExtSel, ALUSrcA, ALUSrcB,
                  ALUOp, RegDst, RegWre, WrRegDSrc, mRD, mWR};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_st(input string nm, input logic [2:0] exp);
        checks++;
        if (state !== exp) begin
            errors++;
            $display("FAIL %s state got %b want %b", nm, state, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input ctl_t exp);
        checks++;
        if (ctl !== exp) begin
            errors++;
            $display("FAIL %s ctl got %b want %b", nm, ctl, exp);
        end
    endtask

    function automatic ctl_t kc(input logic pw, input logic [1:0] ps,
                                input logic ext, input logic sb,
                                input logic sa, input logic [2:0] aop,
                                input logic rd, input logic rw,
                                input logic ws, input logic mr,
                                input logic mw);
        ctl_t c;
        c = '0;
        c.pcwre = pw;  c.pcsrc = ps;  c.ext = ext;
        c.srcb = sb;   c.srca = sa;   c.aluop = aop;
        c.regdst = rd; c.regwre = rw; c.wrsrc = ws;
        c.mrd = mr;    c.mwr = mw;
        return c;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic z,
                                input int n, input logic [14:0] sts,
                                input int key, input ctl_t k);
        vec_t v;
        v.op = op; v.z = z; v.n = n;
        v.st = sts; v.key = key; v.kc = k;
        return v;
    endfunction

    function automatic void push(input logic [2:0] st, input ctl_t c);
        step_t s;
        s.st = st;
        s.c  = c;
        exp_q.push_back(s);
    endfunction

    // Expected per-cycle trace of one instruction, from its class.
    function automatic void model(input logic [5:0] op, input logic z);
        ctl_t c;
        logic [2:0] aop;
        logic sa, sb, ext, rtype, alu, taken;
        exp_q.delete();
        c = '0;
        c.irwre = 1'b1;
        push(3'd0, c);
        alu = 1'b1; sa = 0; sb = 0; ext = 0; rtype = 0; aop = 3'b000;
        case (op)
            6'b000000: rtype = 1;
            6'b000001: begin rtype = 1; aop = 3'b001; end
            6'b000010: begin sb = 1; ext = 1; end
            6'b010001: begin rtype = 1; aop = 3'b100; end
            6'b010000: begin sb = 1; aop = 3'b100; end
            6'b010011: begin rtype = 1; aop = 3'b011; end
            6'b010010: begin sb = 1; aop = 3'b011; end
            6'b011000: begin rtype = 1; sa = 1; aop = 3'b010; end
            6'b100111: begin rtype = 1; aop = 3'b110; end
            6'b100110: begin sb = 1; ext = 1; aop = 3'b110; end
            default:   alu = 1'b0;
        endcase
        if (alu) begin
            push(3'd1, '0);
            push(3'd6, kc(0, 2'b00, ext, sb, sa, aop, 0, 0, 0, 0, 0));
            push(3'd7, kc(1, 2'b00, 0, 0, 0, aop, rtype, 1, 1, 0, 0));
        end else if (op == 6'b110000 || op == 6'b110001) begin
            push(3'd1, '0);
            push(3'd2, kc(0, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0));
            if (op == 6'b110000) begin
                push(3'd3, kc(1, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 0, 1));
            end else begin
                push(3'd3, kc(0, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 1, 0));
                push(3'd4, kc(1, 2'b00, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
            end
        end else if (op == 6'b110100 || op == 6'b110101) begin
            taken = (op == 6'b110100) ? z : !z;
            push(3'd1, '0);
            push(3'd5, kc(1, taken ? 2'b01 : 2'b00, 1, 0, 0, 3'b001,
                          0, 0, 0, 0, 0));
        end else if (op == 6'b111000) begin
            push(3'd1, kc(1, 2'b10, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        end else begin
            push(3'd1, kc(1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        end
    endfunction

    initial begin
        ir_only = '0;
        ir_only.irwre = 1'b1;

        vt.push_back(mk(6'b000000, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 3,
            kc(1, 2'b00, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0)));
        vt.push_back(mk(6'b000001, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 2,
            kc(0, 2'b00, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b110001, 0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 3,
            kc(0, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 1, 0)));
        vt.push_back(mk(6'b110001, 1, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 4,
            kc(1, 2'b00, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0)));
        vt.push_back(mk(6'b110000, 0, 4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0}, 3,
            kc(1, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 0, 1)));
        vt.push_back(mk(6'b110100, 1, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0}, 2,
            kc(1, 2'b01, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b110100, 0, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0}, 2,
            kc(1, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b110101, 0, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0}, 2,
            kc(1, 2'b01, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b110101, 1, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0}, 2,
            kc(1, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b111000, 0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, 1,
            kc(1, 2'b10, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b101010, 0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, 1,
            kc(1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b010000, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 2,
            kc(0, 2'b00, 0, 1, 0, 3'b100, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b011000, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 2,
            kc(0, 2'b00, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b100110, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 2,
            kc(0, 2'b00, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0)));
        vt.push_back(mk(6'b010010, 0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0}, 3,
            kc(1, 2'b00, 0, 0, 0, 3'b011, 0, 1, 1, 0, 0)));

        // Reset for two edges, then release.
        Reset = 1'b1; opcode = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_st($sformatf("reset%0d", i), 3'd0);
            chk_ctl($sformatf("reset%0d", i), '0);
        end
        Reset = 1'b0;
        #1;
        chk_st("release", 3'd0);
        chk_ctl("release", ir_only);

        // Directed vector table.
        for (int v = 0; v < vt.size(); v++) begin
            opcode = vt[v].op;
            zero   = vt[v].z;
            #1;
            for (int c = 0; c < vt[v].n; c++) begin
                chk_st($sformatf("vec%0d cyc%0d", v, c), vt[v].st[4-c]);
                if (c == vt[v].key)
                    chk_ctl($sformatf("vec%0d key", v), vt[v].kc);
                tick();
            end
            chk_st($sformatf("vec%0d latency", v), 3'd0);
        end

        // Reset during MEM of sw suppresses the write.
        opcode = 6'b110000;
        tick(); tick(); tick();
        chk_st("sw mem", 3'd3);
        chk_ctl("sw mem",
            kc(1, 2'b00, 1, 1, 0, 3'b000, 0, 0, 0, 0, 1));
        Reset = 1'b1;
        #1;
        chk_st("sw mem reset", 3'd0);
        chk_ctl("sw mem reset", '0);
        tick();
        Reset = 1'b0;
        #1;
        chk_st("sw after reset", 3'd0);
        chk_ctl("sw after reset", ir_only);

        // Random instruction stream against the trace model.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            logic [5:0] pick[16];
            pick = '{6'b000000, 6'b000001, 6'b000010, 6'b010001,
                     6'b010000, 6'b010011, 6'b010010, 6'b011000,
                     6'b100111, 6'b100110, 6'b110000, 6'b110001,
                     6'b110100, 6'b110101, 6'b111000, 6'b101010};
            if ($urandom_range(0, 3) == 0)
                op = 6'($urandom_range(0, 63));
            else
                op = pick[$urandom_range(0, 15)];
            if (op == 6'b111111)
                op = 6'b101010;
            opcode = op;
            zero   = 1'($urandom_range(0, 1));
            model(op, zero);
            #1;
            for (int c = 0; c < exp_q.size(); c++) begin
                chk_st($sformatf("rnd%0d op%b cyc%0d", n, op, c),
                       exp_q[c].st);
                chk_ctl($sformatf("rnd%0d op%b cyc%0d", n, op, c),
                        exp_q[c].c);
                tick();
            end
        end
        chk_st("rnd end", 3'd0);

        // Sticky halt, then reset out of it.
        opcode = 6'b111111;
        #1;
        chk_ctl("halt if", ir_only);
        tick();
        chk_st("halt id", 3'd1);
        chk_ctl("halt id", '0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_st($sformatf("halt%0d", i), 3'd1);
            chk_ctl($sformatf("halt%0d", i), '0);
        end
        Reset = 1'b1;
        #1;
        chk_ctl("halt reset", '0);
        tick();
        Reset = 1'b0;
        opcode = 6'b000000;
        #1;
        chk_st("halt exit", 3'd0);
        chk_ctl("halt exit", ir_only);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout state got %b want finish", state);
        $fatal(1, "timeout");
    end

endmodule
